// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the multiplier datapath.
package mult_pkg;

    localparam int N_DEF     = 32;
    localparam int CHUNK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int n, input int chunk);
        return (2 * n) / chunk;
    endfunction

    // The final adder only supports a 2N-bit word split into whole slices.
    function automatic bit chunk_fits(input int n, input int chunk);
        return (chunk > 0) && (((2 * n) % chunk) == 0);
    endfunction

endpackage

// File: rtl/csa_final_adder_chunk_adder.sv
// One CHUNK-bit slice of the carry-propagate adder; purely combinational.
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_final_adder.sv
// Resolves the compressor tree's sum/carry rows into a 2N-bit product,
// one CHUNK-bit slice per clock, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a vector pair; in_ready high
// ADD   | rippling one slice per cycle, idx selects the slice
// DONE  | product/cout valid and held until out_ready
module csa_final_adder
    import mult_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] sum_vec,
    input  logic [2*N-1:0] carry_vec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           cout
);

    localparam int W      = 2 * N;
    localparam int NCHUNK = nchunk(N, CHUNK);
    localparam int IDXW   = $clog2(NCHUNK + 1);

    if (!chunk_fits(N, CHUNK)) begin : g_bad_chunk
        $error("csa_final_adder: 2*N must be a multiple of CHUNK");
    end

    state_t            state_q, state_d;
    logic [W-1:0]      sum_q, sum_d;
    logic [W-1:0]      cvec_q, cvec_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      product_q, product_d;
    logic              cout_q, cout_d;

    logic [CHUNK-1:0]  add_a, add_b, add_s;
    logic              add_c;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                add_a = sum_q[k*CHUNK +: CHUNK];
                add_b = cvec_q[k*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_c)
    );

    always_comb begin
        state_d   = state_q;
        sum_d     = sum_q;
        cvec_d    = cvec_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        product_d = product_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                if (in_valid) begin
                    sum_d   = sum_vec;
                    cvec_d  = carry_vec;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        product_d[k*CHUNK +: CHUNK] = add_s;
                    end
                end
                carry_d = add_c;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    cout_d  = add_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sum_q     <= '0;
            cvec_q    <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            product_q <= '0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cvec_q    <= cvec_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            product_q <= product_d;
            cout_q    <= cout_d;
        end
    end

    assign product = product_q;
    assign cout    = cout_q;

endmodule
